instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage upstream of the control decoder. Holds the PC, fetches one instruction at a time
//  over a req/ack instruction-memory port, and presents the instruction with its opcode and funct
//  fields through a valid/ready handshake. When the decode side consumes an instruction, the
//  next PC is taken from that instruction's control outcome: J/JAL, JR, taken BNE, or PC+4.
// PARAMETERS
//  ADDR_W    32            PC / instruction-memory address width (bits)
//  RESET_PC  32'h0000_0000 PC loaded on reset (low 2 bits ignored, forced to 00)
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  imem_req      out  1       instruction fetch request
//  imem_addr     out  ADDR_W  fetch address; stable while imem_req=1
//  imem_ack      in   1       rdata valid this cycle; ignored when imem_req=0
//  imem_rdata    in   32      instruction word
//  instr         out  32      held instruction
//  opcode        out  6       instr[31:26]
//  funct         out  6       instr[5:0]
//  pc_out        out  ADDR_W  PC of held instruction
//  pc_plus4      out  ADDR_W  pc_out+4, for JAL link
//  instr_valid   out  1       instr/pc_out valid
//  instr_ready   in   1       decode consumes when instr_valid && instr_ready
//  jump          in   1       control Jump for the held instruction
//  jump_sel      in   1       0 = J/JAL target, 1 = JR target (rs_data)
//  branch        in   1       control Branch (BNE)
//  alu_zero      in   1       ALU zero flag; BNE taken when 0
//  rs_data       in   ADDR_W  register rs value, JR target
//  halted        out  1       fetch stopped (only with IF_SYSCALL_HALT_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_PC&~3, state=FETCH on release; imem_req=0, instr=0,
//    instr_valid=0, halted=0, imem_addr=pc. Reset mid-fetch abandons the request; a late ack is ignored.
//  - FSM states: FETCH, VALID, HALT.
//  - FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, pc_out<=pc, go VALID.
//    Ack in the first req cycle is legal; minimum latency req->instr_valid = 1 cycle.
//  - VALID: instr_valid=1, imem_req=0; outputs held stable until consumed.
//    On instr_valid && instr_ready, next pc is selected by priority:
//      jump && !jump_sel -> {pc_plus4[31:28], instr[25:0], 2'b00}
//      jump &&  jump_sel -> rs_data with [1:0] forced 00
//      branch && !alu_zero -> pc_plus4 + (sext(instr[15:0]) << 2)
//      else -> pc_plus4
//    Then go to FETCH the following cycle. No delay slot and no speculation: one instruction in flight.
//  - Control inputs are sampled only in the consume cycle.
//  - Arithmetic is modulo 2^ADDR_W: pc 32'hFFFF_FFFC + 4 wraps to 0. Branch offset is sign-extended to ADDR_W.
//  - Ready asserted with valid low has no effect. Ack while in VALID or HALT is ignored.
// CONFIGURATION
//  IF_SYSCALL_HALT_EN defined: when an instruction with opcode=0 and funct=6'b001100 (SYSCALL)
//    is consumed, go to HALT. HALT: imem_req=0, instr_valid=0, halted=1; the state is left only by reset.
//  IF_SYSCALL_HALT_EN undefined: SYSCALL is treated as a normal instruction (next pc = pc_plus4).
//    halted is tied to 0 and there is no HALT state.
// TESTING
//  1 Reset, then ack in the same cycle with rdata=32'h8C01_0004 -> imem_addr=0; instr_valid next cycle;
//    opcode=6'h23; pc_plus4=4.
//  2 Hold instr_ready=0 for 5 cycles -> instr, pc_out and instr_valid stable; imem_req=0 throughout.
//  3 Consume at pc=0x100 with instr=32'h0800_0040, jump=1, jump_sel=0 -> next imem_addr=0x0000_0100.
//    Consume with jump_sel=1, rs_data=0x203 -> imem_addr=0x200.
//  4 BNE at pc=0x40 with imm=16'hFFFE, branch=1, alu_zero=0 -> imem_addr=0x3C.
//    Same instruction with alu_zero=1 -> imem_addr=0x44.
//  5 Consume at pc=0xFFFF_FFFC with no redirect -> imem_addr=0. Drop rst_n while imem_req=1 with
//    an ack 3 cycles later -> pc=RESET_PC, the stale word is not presented.
//  6 With IF_SYSCALL_HALT_EN, consume 32'h0000_000C -> halted=1 and no further imem_req.
//    Without the macro -> fetch continues at pc+4.

Source files
------------

// File: rtl/instr_fetch.sv
//==============================================================================
// Module      : instr_fetch
// Description : Single-issue fetch stage. It holds the PC, fetches one word over
//               a req/ack memory port, presents it to decode with valid/ready,
//               and picks the next PC from the decode outcome (J/JAL, JR, BNE,
//               or PC+4). Optional SYSCALL halt is enabled with the macro
//               IF_SYSCALL_HALT_EN. ADDR_W must be at least 29.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module instr_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump,
    input  logic              jump_sel,
    input  logic              branch,
    input  logic              alu_zero,
    input  logic [ADDR_W-1:0] rs_data,
    output logic              halted
);

    localparam logic [1:0] c_FETCH = 2'd0;
    localparam logic [1:0] c_VALID = 2'd1;
`ifdef IF_SYSCALL_HALT_EN
    localparam logic [1:0] c_HALT  = 2'd2;
`endif

    localparam logic [ADDR_W-1:0] c_ALIGN_MASK  = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] c_RESET_PC_AL = RESET_PC & c_ALIGN_MASK;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [31:0]       instr_q, instr_d;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_j_target;
    logic [ADDR_W-1:0] w_jr_target;
    logic [ADDR_W-1:0] w_br_offset;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_next_pc;

    // Redirect targets are all relative to the held instruction, never the fetch PC.
    assign w_pc_plus4  = pc_out_q + ADDR_W'(4);
    assign w_j_target  = {w_pc_plus4[ADDR_W-1:28], instr_q[25:0], 2'b00};
    assign w_jr_target = rs_data & c_ALIGN_MASK;
    assign w_br_offset = {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
    assign w_br_target = w_pc_plus4 + w_br_offset;

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump && !jump_sel) begin
            w_next_pc = w_j_target;
        end else if (jump) begin
            w_next_pc = w_jr_target;
        end else if (branch && !alu_zero) begin
            w_next_pc = w_br_target;
        end
    end

`ifdef IF_SYSCALL_HALT_EN
    logic w_is_syscall;
    assign w_is_syscall = (instr_q[31:26] == 6'd0) && (instr_q[5:0] == 6'b001100);
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        case (state_q)
            c_FETCH: begin
                if (imem_ack) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = c_VALID;
                end
            end
            c_VALID: begin
                if (instr_ready) begin
                    pc_d = w_next_pc;
`ifdef IF_SYSCALL_HALT_EN
                    state_d = w_is_syscall ? c_HALT : c_FETCH;
`else
                    state_d = c_FETCH;
`endif
                end
            end
`ifdef IF_SYSCALL_HALT_EN
            c_HALT: begin
                state_d = c_HALT;
            end
`endif
            default: begin
                state_d = c_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= c_FETCH;
            pc_q     <= c_RESET_PC_AL;
            pc_out_q <= c_RESET_PC_AL;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
        end
    end

    // The request is masked while reset is held so a reset mid-fetch drops it at once.
    assign imem_req    = rst_n && (state_q == c_FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign pc_out      = pc_out_q;
    assign pc_plus4    = w_pc_plus4;
    assign instr_valid = (state_q == c_VALID);

`ifdef IF_SYSCALL_HALT_EN
    assign halted = (state_q == c_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//==============================================================================
// Module      : tb_instr_fetch
// Description : Directed bench for instr_fetch with a transaction-level model.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_SYSCALL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_ready = 1'b0;
    logic        jump = 1'b0;
    logic        jump_sel = 1'b0;
    logic        branch = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] rs_data = 32'h0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 1'b0;

    instr_fetch #(
        .ADDR_W   (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .funct       (funct),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump        (jump),
        .jump_sel    (jump_sel),
        .branch      (branch),
        .alu_zero    (alu_zero),
        .rs_data     (rs_data),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    // Model: next PC from the architectural rules, in plain 32-bit arithmetic.
    function automatic logic [31:0] model_next_pc(input logic [31:0] ins, input logic [31:0] pc,
                                                  input logic j, input logic js, input logic b,
                                                  input logic z, input logic [31:0] rs);
        logic [31:0] p4;
        int          off;
        p4  = pc + 32'd4;
        off = int'($signed(ins[15:0]));
        if (j && !js) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        else if (j) return rs & 32'hFFFF_FFFC;
        else if (b && !z) return p4 + 32'(off * 4);
        return p4;
    endfunction

    function automatic bit model_is_syscall(input logic [31:0] ins);
        return (ins[31:26] == 6'd0) && (ins[5:0] == 6'd12);
    endfunction

    logic [31:0] m_pc     = RESET_PC;
    logic [31:0] m_instr  = 32'h0;
    logic [31:0] m_pc_out = RESET_PC;
    logic        m_have   = 1'b0;
    logic        m_halt   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= RESET_PC & 32'hFFFF_FFFC;
            m_instr <= 32'h0;
            m_have  <= 1'b0;
            m_halt  <= 1'b0;
        end else if (!m_have && !m_halt) begin
            if (imem_ack) begin
                m_have   <= 1'b1;
                m_instr  <= imem_rdata;
                m_pc_out <= m_pc;
            end
        end else if (m_have && instr_ready) begin
            m_pc   <= model_next_pc(m_instr, m_pc_out, jump, jump_sel, branch, alu_zero, rs_data);
            m_have <= 1'b0;
            if (HALT_EN && model_is_syscall(m_instr)) m_halt <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("imem_req",    32'(imem_req),    32'(rst_n && !m_have && !m_halt));
            chk("imem_addr",   imem_addr,        m_pc);
            chk("instr_valid", 32'(instr_valid), 32'(m_have));
            chk("instr",       instr,            m_instr);
            chk("opcode",      32'(opcode),      32'(m_instr[31:26]));
            chk("funct",       32'(funct),       32'(m_instr[5:0]));
            chk("halted",      32'(halted),      32'(m_halt));
            if (m_have) begin
                chk("pc_out",   pc_out,   m_pc_out);
                chk("pc_plus4", pc_plus4, m_pc_out + 32'd4);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts and ends one time unit after a rising edge, DUT waiting in FETCH.
    task automatic fetch(input logic [31:0] w, input int dly, input bit rdy_noise);
        if (rdy_noise) instr_ready = 1'b1;
        repeat (dly) tick();
        instr_ready = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = w;
        tick();
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    task automatic consume(input int hold, input logic j, input logic js, input logic b,
                           input logic z, input logic [31:0] rs);
        repeat (hold) tick();
        jump        = j;
        jump_sel    = js;
        branch      = b;
        alu_zero    = z;
        rs_data     = rs;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        jump        = 1'b0;
        jump_sel    = 1'b0;
        branch      = 1'b0;
        alu_zero    = 1'b0;
        rs_data     = 32'h0;
    endtask

    initial begin
        #1;
        rst_n   = 1'b0;
        started = 1'b1;
        #1;
        chk("reset_req",   32'(imem_req),    32'd0);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_instr", instr,            32'h0);
        chk("reset_addr",  imem_addr,        32'h0);
        repeat (3) tick();

        // Release reset and acknowledge in the very first request cycle.
        rst_n = 1'b1;
        #1;
        chk("first_req",  32'(imem_req), 32'd1);
        chk("first_addr", imem_addr,     32'h0);
        fetch(32'h8C01_0004, 0, 1'b0);
        chk("lw_valid",  32'(instr_valid), 32'd1);
        chk("lw_opcode", 32'(opcode),      32'h23);
        chk("lw_pc4",    pc_plus4,         32'h4);
        chk("lw_req",    32'(imem_req),    32'd0);

        // Hold without ready; a stray ack must not disturb the held word.
        repeat (2) tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        repeat (2) tick();
        chk("hold_instr", instr,            32'h8C01_0004);
        chk("hold_pc",    pc_out,           32'h0);
        chk("hold_valid", 32'(instr_valid), 32'd1);
        consume(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0103);
        chk("jr_mask", imem_addr, 32'h100);

        fetch(32'h0800_0040, 0, 1'b0);
        consume(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("j_target", imem_addr, 32'h100);
        fetch(32'h0800_0040, 0, 1'b0);
        consume(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0203);
        chk("jr_target", imem_addr, 32'h200);
        fetch(32'h0800_0010, 1, 1'b0);
        consume(1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("j_to_40", imem_addr, 32'h40);

        fetch(32'h1422_FFFE, 0, 1'b0);
        chk("bne_pc", pc_out, 32'h40);
        consume(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("bne_taken", imem_addr, 32'h3C);
        fetch(32'h0800_0010, 0, 1'b0);
        consume(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        fetch(32'h1422_FFFE, 0, 1'b0);
        consume(0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        chk("bne_not_taken", imem_addr, 32'h44);
        fetch(32'h0800_0040, 0, 1'b0);
        consume(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("jump_over_branch", imem_addr, 32'h100);

        // Wrap of the sequential PC at the top of the address space.
        fetch(32'h0000_0000, 0, 1'b0);
        consume(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        chk("jr_top", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h2001_0001, 2, 1'b1);
        chk("top_pc",  pc_out,   32'hFFFF_FFFC);
        chk("top_pc4", pc_plus4, 32'h0);
        consume(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        fetch(32'h0000_0000, 0, 1'b0);
        consume(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("seq_addr", imem_addr, 32'h4);

        // Reset during an outstanding request, with an ack arriving inside reset.
        rst_n = 1'b0;
        #1;
        chk("midrst_req",  32'(imem_req), 32'd0);
        chk("midrst_addr", imem_addr,     32'h0);
        repeat (3) tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_valid", 32'(instr_valid), 32'd0);
        chk("post_rst_instr", instr,            32'h0);
        chk("post_rst_req",   32'(imem_req),    32'd1);
        repeat (2) tick();

        fetch(32'h0000_000C, 0, 1'b0);
        chk("sys_funct", 32'(funct), 32'h0C);
        consume(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef IF_SYSCALL_HALT_EN
        chk("sys_halted", 32'(halted),   32'd1);
        chk("sys_no_req", 32'(imem_req), 32'd0);
        repeat (2) tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_ack   = 1'b0;
        repeat (3) tick();
        chk("halt_stays", 32'(halted),      32'd1);
        chk("halt_valid", 32'(instr_valid), 32'd0);
`else
        chk("sys_not_halted", 32'(halted), 32'd0);
        chk("sys_next",       imem_addr,   32'h4);
        fetch(32'h8C01_0004, 0, 1'b0);
        chk("sys_after_pc", pc_out, 32'h4);
        consume(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("sys_after_next", imem_addr, 32'h8);
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
